// File: rtl/vga_sync.sv
// vga_sync: VGA timing generator and pixel output stage (640x480@60 Hz by default).
// Free-running x/y counters drive the sync windows and the visible-area flag.
// Sync and colour leave through a registered output stage.
// Optional build macro VGA_SYNC_PREFETCH_EN adds one register stage on the sync/active
// path, which raises latency from 1 to 2. rgb_in can then come from a
// synchronous-read framebuffer addressed directly by x/y.
module vga_sync #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       vclk,
    input  logic       rst,
    input  logic [7:0] rgb_in,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       active,
    output logic       frame_start,
    output logic       hsync,
    output logic       vsync,
    output logic [2:0] red,
    output logic [2:0] green,
    output logic [1:0] blue
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Counter-width constants, so every compare below is 10 bits against 10 bits.
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] r_x;
    logic [9:0] r_y;
    logic       w_x_last;
    logic       w_y_last;
    logic       w_active;
    logic       w_hsync;
    logic       w_vsync;

    // Signals entering the output stage (direct, or through the prefetch stage).
    logic       w_st_hsync;
    logic       w_st_vsync;
    logic       w_st_active;

    logic       r_hsync;
    logic       r_vsync;
    logic [7:0] r_rgb;

    assign w_x_last = (r_x == H_LAST);
    assign w_y_last = (r_y == V_LAST);

    // Pixel/line counters: x advances every cycle, y advances when x wraps.
    always_ff @(posedge vclk) begin
        // NOTE: non-blocking assignments here, so r_y sees the pre-edge r_x compare
        // no matter how the statements are ordered.
        if (rst) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_x_last) begin
            r_x <= '0;
            r_y <= w_y_last ? '0 : r_y + 10'd1;
        end else begin
            r_x <= r_x + 10'd1;
        end
    end

    // Timing decode straight from the counter registers, aligned with x/y.
    assign w_active = (r_x < H_VIS) && (r_y < V_VIS);
    assign w_hsync  = !((r_x >= HS_START) && (r_x < HS_END));
    assign w_vsync  = !((r_y >= VS_START) && (r_y < VS_END));

    assign x           = r_x;
    assign y           = r_y;
    assign active      = w_active;
    assign frame_start = (r_x == 10'd0) && (r_y == 10'd0);

`ifdef VGA_SYNC_PREFETCH_EN
    logic r_pf_hsync;
    logic r_pf_vsync;
    logic r_pf_active;

    // Prefetch stage: holds sync/active one cycle while the framebuffer read completes.
    always_ff @(posedge vclk) begin
        if (rst) begin
            r_pf_hsync  <= 1'b1;
            r_pf_vsync  <= 1'b1;
            r_pf_active <= 1'b0;
        end else begin
            r_pf_hsync  <= w_hsync;
            r_pf_vsync  <= w_vsync;
            r_pf_active <= w_active;
        end
    end

    assign w_st_hsync  = r_pf_hsync;
    assign w_st_vsync  = r_pf_vsync;
    assign w_st_active = r_pf_active;
`else
    assign w_st_hsync  = w_hsync;
    assign w_st_vsync  = w_vsync;
    assign w_st_active = w_active;
`endif

    // Output stage: register sync and capture colour, blanked outside the visible area.
    always_ff @(posedge vclk) begin
        if (rst) begin
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_rgb   <= 8'h00;
        end else begin
            r_hsync <= w_st_hsync;
            r_vsync <= w_st_vsync;
            r_rgb   <= w_st_active ? rgb_in : 8'h00;
        end
    end

    assign hsync = r_hsync;
    assign vsync = r_vsync;
    assign red   = r_rgb[7:5];
    assign green = r_rgb[4:2];
    assign blue  = r_rgb[1:0];

endmodule

// File: tb/tb_vga_sync.sv
// tb_vga_sync: self-checking bench for vga_sync using a reduced timing set (30x17 frame).
// Expected sync/colour values are pushed when each coordinate's stimulus is driven.
// They are popped L cycles later, when the registered outputs present that coordinate.
`timescale 1ns/1ps
module tb_vga_sync;

    localparam int H_ACTIVE = 16;
    localparam int H_FP     = 4;
    localparam int H_SYNC   = 6;
    localparam int H_BP     = 4;
    localparam int V_ACTIVE = 10;
    localparam int V_FP     = 2;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 3;

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;   // 30
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;   // 17
    localparam int FRAME    = H_TOTAL * V_TOTAL;                 // 510
    localparam int HS_START = H_ACTIVE + H_FP;                   // 20
    localparam int HS_END   = HS_START + H_SYNC;                 // 26
    localparam int VS_START = V_ACTIVE + V_FP;                   // 12
    localparam int VS_END   = VS_START + V_SYNC;                 // 14

`ifdef VGA_SYNC_PREFETCH_EN
    localparam int L = 2;
`else
    localparam int L = 1;
`endif

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic [7:0] col;
    } exp_t;

    logic       vclk = 1'b0;
    logic       rst;
    logic [7:0] rgb_in;
    logic [9:0] x;
    logic [9:0] y;
    logic       active;
    logic       frame_start;
    logic       hsync;
    logic       vsync;
    logic [2:0] red;
    logic [2:0] green;
    logic [1:0] blue;
    logic [7:0] col;

    assign col = {red, green, blue};

    vga_sync #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) dut (
        .vclk        (vclk),
        .rst         (rst),
        .rgb_in      (rgb_in),
        .x           (x),
        .y           (y),
        .active      (active),
        .frame_start (frame_start),
        .hsync       (hsync),
        .vsync       (vsync),
        .red         (red),
        .green       (green),
        .blue        (blue)
    );

    always #5 vclk = ~vclk;

    int         n_checks = 0;
    int         n_fail   = 0;
    exp_t       sb[$];
    int         mx;
    int         my;
    int         cyc = 0;
    logic [7:0] prev_val = 8'h00;
    bit         mode_ff  = 1'b0;
    bit         count_ff = 1'b0;
    int         ff_cnt   = 0;
    int         hs_fall_cyc = -1;
    int         vs_fall_cyc = -1;
    int         fs_cyc      = -1;
    logic       prev_hs = 1'b1;
    logic       prev_vs = 1'b1;
    logic       prev_fs = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic exp_t exp_for(input int cx, input int cy, input logic [7:0] rgb);
        exp_t e;
        e.hs  = !((cx >= HS_START) && (cx < HS_END));
        e.vs  = !((cy >= VS_START) && (cy < VS_END));
        e.col = ((cx < H_ACTIVE) && (cy < V_ACTIVE)) ? rgb : 8'h00;
        return e;
    endfunction

    // One clock: sample at the falling edge, check against the model, then drive the next
    // coordinate's colour and push its expected output. do_rst asserts rst for the next edge.
    task automatic step(input bit do_rst);
        exp_t       e;
        logic [7:0] cur_val;
        @(negedge vclk);
        cyc++;
        if (rst) begin
            mx = 0;
            my = 0;
            sb.delete();
            check("rst_hsync", hsync, 1'b1);
            check("rst_vsync", vsync, 1'b1);
            check("rst_colour", col, 8'h00);
            hs_fall_cyc = -1;
            vs_fall_cyc = -1;
            prev_hs = 1'b1;
            prev_vs = 1'b1;
            prev_fs = 1'b1;
            fs_cyc  = cyc;
            rst = 1'b0;
        end else begin
            if (mx == H_TOTAL - 1) begin
                mx = 0;
                my = (my == V_TOTAL - 1) ? 0 : my + 1;
            end else begin
                mx++;
            end
            if (sb.size() >= L) begin
                e = sb.pop_front();
                check("sb_hsync", hsync, e.hs);
                check("sb_vsync", vsync, e.vs);
                check("sb_colour", col, e.col);
            end
            if (!hsync || !vsync) check("sync_blank", col, 8'h00);
            if (count_ff && col == 8'hFF) ff_cnt++;
            if (prev_hs && !hsync) begin
                if (hs_fall_cyc >= 0) check("hs_period", cyc - hs_fall_cyc, H_TOTAL);
                check("hs_fall_x", x, (HS_START + L) % H_TOTAL);
                hs_fall_cyc = cyc;
            end
            if (!prev_hs && hsync && hs_fall_cyc >= 0) check("hs_width", cyc - hs_fall_cyc, H_SYNC);
            if (prev_vs && !vsync) begin
                check("vs_fall_x", x, L % H_TOTAL);
                check("vs_fall_y", y, VS_START);
                vs_fall_cyc = cyc;
            end
            if (!prev_vs && vsync && vs_fall_cyc >= 0)
                check("vs_width", cyc - vs_fall_cyc, V_SYNC * H_TOTAL);
            if (frame_start && !prev_fs && fs_cyc >= 0) check("fs_period", cyc - fs_cyc, FRAME);
            if (frame_start) fs_cyc = cyc;
            prev_hs = hsync;
            prev_vs = vsync;
            prev_fs = frame_start;
        end
        check("x", x, mx);
        check("y", y, my);
        check("active", active, (mx < H_ACTIVE) && (my < V_ACTIVE));
        check("frame_start", frame_start, (mx == 0) && (my == 0));
        cur_val  = mode_ff ? 8'hFF : mx[7:0];
        rgb_in   = (L == 2) ? prev_val : cur_val;
        prev_val = cur_val;
        sb.push_back(exp_for(mx, my, cur_val));
        if (do_rst) rst = 1'b1;
    endtask

    initial begin
        int guard;
        rst    = 1'b1;
        rgb_in = 8'h00;

        // Reset held for three edges; the third sample (inside step) releases it.
        repeat (2) begin
            @(negedge vclk);
            cyc++;
            check("rst_x", x, 0);
            check("rst_y", y, 0);
            check("rst_hsync", hsync, 1'b1);
            check("rst_vsync", vsync, 1'b1);
            check("rst_colour", col, 8'h00);
            check("rst_active", active, 1'b1);
            check("rst_frame_start", frame_start, 1'b1);
        end
        step(1'b0);

        // Latency: colour follows x[7:0] delayed by L, blanked outside the visible area.
        repeat (2 * FRAME) step(1'b0);

        // Blanking: constant full-scale colour; count lit pixels over one frame period.
        mode_ff = 1'b1;
        repeat (10) step(1'b0);
        count_ff = 1'b1;
        ff_cnt   = 0;
        repeat (FRAME) step(1'b0);
        count_ff = 1'b0;
        check("ff_pixels", ff_cnt, H_ACTIVE * V_ACTIVE);

        // Mid-frame reset: one-cycle pulse while the counters sit at (10,5).
        mode_ff = 1'b0;
        guard = 0;
        while (!(mx == 9 && my == 5) && guard < 2 * FRAME) begin
            step(1'b0);
            guard++;
        end
        check("mfr_reach", (mx == 9 && my == 5), 1'b1);
        step(1'b1);
        check("mfr_pos_x", mx, 10);
        step(1'b0);
        repeat (FRAME + 40) step(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
